// File: rtl/instr_encoder_pkg.sv
// Shared MIPS instruction types, encode helpers and run FSM state for instr_encoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package instr_encoder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        OPCODE_RTYPE = 6'h00, OPCODE_J     = 6'h02, OPCODE_JAL   = 6'h03,
        OPCODE_BEQ   = 6'h04, OPCODE_BNE   = 6'h05, OPCODE_ADDI  = 6'h08,
        OPCODE_ADDIU = 6'h09, OPCODE_SLTI  = 6'h0A, OPCODE_ANDI  = 6'h0C,
        OPCODE_ORI   = 6'h0D, OPCODE_XORI  = 6'h0E, OPCODE_LUI   = 6'h0F,
        OPCODE_LW    = 6'h23, OPCODE_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FUNC_SLL  = 6'h00, FUNC_SRL  = 6'h02, FUNC_SRA  = 6'h03, FUNC_JR   = 6'h08,
        FUNC_ADD  = 6'h20, FUNC_ADDU = 6'h21, FUNC_SUB  = 6'h22, FUNC_SUBU = 6'h23,
        FUNC_AND  = 6'h24, FUNC_OR   = 6'h25, FUNC_XOR  = 6'h26, FUNC_NOR  = 6'h27,
        FUNC_SLT  = 6'h2A, FUNC_SLTU = 6'h2B
    } func_e;

    typedef enum logic [1:0] {ITYPE_R, ITYPE_I, ITYPE_J} instr_type_e;

    typedef enum logic {ENC_IDLE, ENC_RUN} enc_state_e;

    typedef struct packed {
        opcode_e     opcode;
        func_e       func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } enc_req_t;

    // Same type derivation the decoder uses, so encode/decode round-trip.
    function automatic instr_type_e get_instr_type(input opcode_e op);
        case (op)
            OPCODE_RTYPE:         return ITYPE_R;
            OPCODE_J, OPCODE_JAL: return ITYPE_J;
            default:              return ITYPE_I;
        endcase
    endfunction

    function automatic logic uses_shamt(input func_e f);
        return (f == FUNC_SLL) || (f == FUNC_SRL) || (f == FUNC_SRA);
    endfunction

    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OPCODE_RTYPE, OPCODE_J, OPCODE_JAL, OPCODE_BEQ, OPCODE_BNE,
            OPCODE_ADDI, OPCODE_ADDIU, OPCODE_SLTI, OPCODE_ANDI, OPCODE_ORI,
            OPCODE_XORI, OPCODE_LUI, OPCODE_LW, OPCODE_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic func_known(input logic [5:0] f);
        case (f)
            FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_JR, FUNC_ADD, FUNC_ADDU, FUNC_SUB,
            FUNC_SUBU, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR, FUNC_SLT,
            FUNC_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic word_t encode_rtype(input enc_req_t r);
        return {r.opcode, r.rs, r.rt, r.rd, r.shamt, r.func};
    endfunction

    function automatic word_t encode_itype(input enc_req_t r);
        return {r.opcode, r.rs, r.rt, r.imm};
    endfunction

    function automatic word_t encode_jtype(input enc_req_t r);
        return {r.opcode, r.target};
    endfunction

endpackage

// File: rtl/instr_enc_buf.sv
// Synchronous FIFO of encoded words between request side and imem write side.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with flags.
// Ports: clk, rst_n (sync, active-low), push_vld/push_dat, pop_vld, head_dat, full, empty.
module instr_enc_buf
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_vld,
    input  word_t push_dat,
    input  logic  pop_vld,
    output word_t head_dat,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_vld  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction field requests into MIPS words and streams a run of them into imem.
// Latency: one cycle from request acceptance to wr_en when the buffer is empty.
// Backpressure: wr_rdy low stalls writes (outputs held); buffer full or run fully accepted drops req_rdy.
// Ports: clk, rst_n (sync, active-low); start/base_addr/len/busy/done run control;
//        req_* request channel; wr_en/wr_rdy/wr_addr/wr_data imem write; err/err_idx legality.
// Optional legality checking is compiled in with INSTR_ENCODER_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 10,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_func,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              wr_en,
    input  logic              wr_rdy,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [LEN_W-1:0]  err_idx
);

    enc_state_e        state, state_nxt;
    logic [LEN_W-1:0]  len_q, acc_cnt, wr_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    enc_req_t          req;
    word_t             enc_word, buf_head;
    logic              buf_full, buf_empty;
    logic              run_start, zero_start, accept, wr_fire, last_wr;

    assign req = '{opcode: opcode_e'(req_opcode), func: func_e'(req_func),
                   rs: req_rs, rt: req_rt, rd: req_rd, shamt: req_shamt,
                   imm: req_imm, target: req_target};

    always_comb begin
        enc_word = encode_itype(req);
        case (get_instr_type(req.opcode))
            ITYPE_R: enc_word = encode_rtype(req);
            ITYPE_J: enc_word = encode_jtype(req);
            default: enc_word = encode_itype(req);
        endcase
    end

    assign run_start  = (state == ENC_IDLE) && start && (len != '0);
    assign zero_start = (state == ENC_IDLE) && start && (len == '0);
    assign req_rdy    = (state == ENC_RUN) && !buf_full && (acc_cnt < len_q);
    assign accept     = req_vld && req_rdy;
    assign wr_en      = !buf_empty;
    // Head of an empty buffer is stale storage; present zero instead.
    assign wr_data    = buf_empty ? '0 : buf_head;
    assign wr_addr    = addr_q;
    assign wr_fire    = wr_en && wr_rdy;
    assign last_wr    = (state == ENC_RUN) && wr_fire && ((wr_cnt + LEN_W'(1)) == len_q);
    assign busy       = (state == ENC_RUN);
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ENC_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENC_IDLE: if (run_start) state_nxt = ENC_RUN;
            ENC_RUN:  if (last_wr)   state_nxt = ENC_IDLE;
            default:  state_nxt = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= zero_start || last_wr;
            if (run_start) begin
                len_q   <= len;
                acc_cnt <= '0;
                wr_cnt  <= '0;
                addr_q  <= base_addr;
            end else begin
                if (accept) acc_cnt <= acc_cnt + LEN_W'(1);
                if (wr_fire) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    wr_cnt <= wr_cnt + LEN_W'(1);
                end
            end
        end
    end

    instr_enc_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept),
        .push_dat (enc_word),
        .pop_vld  (wr_fire),
        .head_dat (buf_head),
        .full     (buf_full),
        .empty    (buf_empty)
    );

`ifdef INSTR_ENCODER_CHECK_EN
    logic             illegal;
    logic             err_q;
    logic [LEN_W-1:0] err_idx_q;

    always_comb begin
        illegal = 1'b0;
        if (!opcode_known(req_opcode)) begin
            illegal = 1'b1;
        end else if (req.opcode == OPCODE_RTYPE) begin
            if (!func_known(req_func))                        illegal = 1'b1;
            if ((req.shamt != '0) && !uses_shamt(req.func))   illegal = 1'b1;
            if (uses_shamt(req.func) && (req.rs != '0))       illegal = 1'b1;
        end else if ((req.opcode == OPCODE_LUI) && (req.rs != '0)) begin
            illegal = 1'b1;
        end
    end

    // Only the first illegal word of a run is recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (run_start) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (accept && illegal && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= acc_cnt;
        end
    end

    assign err     = err_q;
    assign err_idx = err_idx_q;
`else
    assign err     = 1'b0;
    assign err_idx = '0;
`endif

endmodule
